spectrum_line_feeder: RTL and testbench
=======================================

Name: spectrum_line_feeder

Overview:
- Sits directly upstream of the LCD spectrum drawing stage. It buffers one FFT magnitude frame in a ping-pong RAM.
- Supplies the drawing stage with the bin index (line_cnt) and the bar length (line_length) in answer to its data_req/wr_over pulses.
- Scales and saturates magnitudes to the LCD width. Swaps banks only at a display-frame boundary, so a bar set never tears.

Parameters:
- N_BINS, 64, number of displayed bins; N_BINS*6+8 must be <= V_LCD_DISP.
- V_LCD_DISP, 480, LCD rows.
- H_LCD_DISP, 800, LCD columns; bar length saturates at H_LCD_DISP-1.
- MAG_SHIFT, 4, right shift applied to fft_mag before saturation.

Ports:
- lcd_clk  in  1  sole clock: FFT write side and LCD read side
- sys_rst_n  in  1  reset, asynchronous, active-low
- fft_mag  in  16  unsigned magnitude of current bin
- fft_valid  in  1  fft_mag valid this cycle
- fft_sop  in  1  first bin of an FFT frame (qualified by fft_valid)
- fft_eop  in  1  last bin of an FFT frame (qualified by fft_valid)
- pixel_xpos  in  11  current LCD column
- pixel_ypos  in  11  current LCD row
- data_req  in  1  1-cycle pulse: present next bar length
- wr_over  in  1  1-cycle pulse: current bar drawn, advance bin
- line_cnt  out  7  bin index being drawn
- line_length  out  16  bar length in pixels for line_cnt
- frame_swap  out  1  1-cycle pulse when read/write banks swap

Behaviour:
- Reset values: line_cnt=0, line_length=0, frame_swap=0, rd_bank=0, wr_bank=1, wr_addr=0, wr_full=0, spec_valid=0, pend_len=0. RAM contents are not reset.
- Write side:
  - fft_valid&fft_sop writes fft_mag at address 0 of wr_bank, sets wr_addr=1 and clears wr_full.
  - A later fft_valid writes at wr_addr and increments it.
  - Writes with wr_addr>=N_BINS are dropped; wr_addr saturates at N_BINS.
- Frame completion:
  - fft_valid&fft_eop with total written count >= N_BINS sets wr_full.
  - An eop with fewer bins leaves wr_full=0, and that frame is discarded.
  - fft_valid before any sop after reset is ignored.
- Read prefetch (3-stage pipeline):
  - Whenever line_cnt changes (and once after reset), stage1 registers the address {rd_bank,line_cnt}.
  - Stage2 is the synchronous RAM read.
  - Stage3 computes pend_len = min(dout>>MAG_SHIFT, H_LCD_DISP-1), or 0 if spec_valid=0.
  - pend_len is ready 3 cycles after line_cnt changes, well before the next data_req (>=800 cycles apart).
- data_req: line_length <= pend_len on the next edge. line_length is then stable for the whole drawn row.
- wr_over:
  - If line_cnt<N_BINS-1, line_cnt increments.
  - If line_cnt==N_BINS-1 (frame wrap), line_cnt <= 0. In the same cycle, if wr_full=1, swap rd_bank/wr_bank, clear wr_full, set spec_valid=1, and pulse frame_swap.
  - Prefetch restarts with the new rd_bank.
- Resync: at pixel_xpos==0 and pixel_ypos==0, line_cnt is forced to 0 and prefetch restarts. No swap happens at resync; a swap occurs only on wrap.
- Simultaneous events:
  - An FFT write in the same cycle as a swap goes to the pre-swap wr_bank, then wr_addr continues in the new wr_bank. The frame in progress is therefore corrupt: wr_full stays 0 until the next sop.
  - An eop completing in the same cycle as a wrap: the swap uses the old wr_full=0; the new full flag takes effect at the next wrap.
  - data_req and wr_over are never simultaneous. If both occur, wr_over has priority.
- Reset mid-operation: all registers return to their reset values at once. spec_valid=0 forces all bars to length 0 until the first complete frame swaps in.

Decomposition:
- Shared package holds N_BINS, H_LCD_DISP, V_LCD_DISP, MAG_SHIFT, the ROW_PITCH=6 and ROW_OFFSET=8 constants, and the bank-select encoding.
- One sub-module, spectrum_dpram: 2*N_BINS x 16, one write port and one synchronous read port (1-cycle latency), on lcd_clk.

Test Plan:
- Reset, no FFT input, one full display frame -> line_cnt steps 0..63 then back to 0; line_length=0 on every row; frame_swap never pulses.
- FFT frame of 64 bins with mag=i*16 (sop at i=0, eop at i=63), then one display wrap -> frame_swap pulses once; the next frame shows line_length=i for bin i.
- Bin with mag=16'hFFFF, MAG_SHIFT=4 -> line_length=799 (saturated). mag=16'h0010 -> 1.
- Frame with eop after 30 bins following a good frame -> no swap at wrap; the previous lengths persist.
- 100-bin FFT frame -> bins 64..99 dropped; the frame is accepted and shows bins 0..63.
- Force line_cnt=17 mid-frame, then drive pixel_xpos=0, pixel_ypos=0 -> line_cnt=0 next cycle; line_length after the following data_req equals bin 0's scaled value.

Source files
------------

// File: rtl/spectrum_line_feeder_pkg.sv
// Shared constants, bank encoding and magnitude scaling for the spectrum line feeder.
// N_BINS*ROW_PITCH+ROW_OFFSET must stay within V_LCD_DISP so every bar fits on screen.
package spectrum_line_feeder_pkg;

    localparam int N_BINS     = 64;
    localparam int V_LCD_DISP = 480;
    localparam int H_LCD_DISP = 800;
    localparam int MAG_SHIFT  = 4;
    localparam int ROW_PITCH  = 6;
    localparam int ROW_OFFSET = 8;

    localparam int BIN_W = $clog2(N_BINS);
    localparam int CNT_W = 7;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_t;

    // Bar length in pixels: shifted magnitude clamped to the last LCD column.
    function automatic logic [15:0] scale_mag(input logic [15:0] mag,
                                              input int shift,
                                              input int h_disp);
        logic [15:0] shifted;
        shifted = mag >> shift;
        return (shifted > 16'(h_disp - 1)) ? 16'(h_disp - 1) : shifted;
    endfunction

endpackage

// File: rtl/spectrum_line_feeder_dpram.sv
// Ping-pong magnitude store: one write port, one synchronous read port (1-cycle latency).
// The bank bit is the address MSB, so both frames share one array.
module spectrum_dpram
    import spectrum_line_feeder_pkg::*;
#(
    parameter int ADDR_W = BIN_W + 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_line_feeder.sv
// Buffers one FFT magnitude frame in a ping-pong RAM and feeds bar lengths to the LCD
// drawing stage; banks swap only at the display-frame wrap so a bar set never tears.
module spectrum_line_feeder
    import spectrum_line_feeder_pkg::*;
(
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] fft_mag,
    input  logic        fft_valid,
    input  logic        fft_sop,
    input  logic        fft_eop,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic        data_req,
    input  logic        wr_over,
    output logic [6:0]  line_cnt,
    output logic [15:0] line_length,
    output logic        frame_swap
);

    localparam int ADDR_W = BIN_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(N_BINS - 1);
    localparam logic [CNT_W-1:0] BIN_LIMIT = CNT_W'(N_BINS);

    bank_t             rd_bank;
    bank_t             wr_bank;
    logic [CNT_W-1:0]  wr_addr;
    logic              wr_active;
    logic              frame_ok;
    logic              wr_full;
    logic              spec_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_waddr;
    logic [BIN_W-1:0]  wr_slot;
    logic [15:0]       ram_dout;
    logic [15:0]       pend_len;
    logic              ram_we;
    logic              wrap;
    logic              do_swap;
    logic              resync;
    logic              eop_full;

    always_comb begin
        ram_we    = fft_valid && (fft_sop || (wr_active && (wr_addr < BIN_LIMIT)));
        wr_slot   = fft_sop ? '0 : wr_addr[BIN_W-1:0];
        ram_waddr = {wr_bank, wr_slot};
        wrap      = wr_over && (line_cnt == LAST_BIN);
        do_swap   = wrap && wr_full;
        resync    = (pixel_xpos == '0) && (pixel_ypos == '0);
        eop_full  = fft_valid && fft_eop && !fft_sop && wr_active && (wr_addr >= LAST_BIN);
    end

    spectrum_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_ram (
        .clk   (lcd_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (fft_mag),
        .raddr (rd_addr),
        .rdata (ram_dout)
    );

    // A swap mid-frame splits that frame across banks, so frame_ok blocks its completion.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr   <= '0;
            wr_active <= 1'b0;
            frame_ok  <= 1'b0;
            wr_full   <= 1'b0;
        end else begin
            if (fft_valid && fft_sop) begin
                wr_addr   <= CNT_W'(1);
                wr_active <= 1'b1;
                frame_ok  <= 1'b1;
                wr_full   <= 1'b0;
            end else if (fft_valid && wr_active && (wr_addr < BIN_LIMIT)) begin
                wr_addr <= wr_addr + CNT_W'(1);
            end
            if (eop_full && frame_ok) begin
                wr_full <= 1'b1;
            end
            if (do_swap) begin
                wr_full  <= 1'b0;
                frame_ok <= 1'b0;
            end
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_cnt    <= '0;
            line_length <= '0;
            frame_swap  <= 1'b0;
            rd_bank     <= BANK_0;
            wr_bank     <= BANK_1;
            spec_valid  <= 1'b0;
        end else begin
            frame_swap <= do_swap;
            if (wr_over) begin
                line_cnt <= wrap ? '0 : line_cnt + CNT_W'(1);
                if (do_swap) begin
                    rd_bank    <= wr_bank;
                    wr_bank    <= rd_bank;
                    spec_valid <= 1'b1;
                end
            end else if (data_req) begin
                line_length <= pend_len;
            end
            if (resync) begin
                line_cnt <= '0;
            end
        end
    end

    // Free-running prefetch: address, RAM read, then scale; settles 3 cycles after a change.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr  <= '0;
            pend_len <= '0;
        end else begin
            rd_addr  <= {rd_bank, line_cnt[BIN_W-1:0]};
            pend_len <= spec_valid ? scale_mag(ram_dout, MAG_SHIFT, H_LCD_DISP) : '0;
        end
    end

endmodule

// File: tb/tb_spectrum_line_feeder.sv
// Directed bench for spectrum_line_feeder: a small displayed/staged frame model feeds a
// scoreboard of expected bar lengths that are compared after each data_req.
module tb_spectrum_line_feeder;
    import spectrum_line_feeder_pkg::*;

    logic        lcd_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] fft_mag = '0;
    logic        fft_valid = 1'b0;
    logic        fft_sop = 1'b0;
    logic        fft_eop = 1'b0;
    logic [10:0] pixel_xpos = 11'd1;
    logic [10:0] pixel_ypos = 11'd1;
    logic        data_req = 1'b0;
    logic        wr_over = 1'b0;
    logic [6:0]  line_cnt;
    logic [15:0] line_length;
    logic        frame_swap;

    int n_compared = 0;
    int n_mismatched = 0;
    int swaps_seen = 0;
    int swaps_expected = 0;

    logic [15:0] frame_mag [0:127];
    int          shown_len [0:63];
    int          staged_len [0:63];
    bit          staged_full = 1'b0;
    logic [15:0] exp_q [$];

    always #5 lcd_clk = ~lcd_clk;

    spectrum_line_feeder dut (
        .lcd_clk     (lcd_clk),
        .sys_rst_n   (sys_rst_n),
        .fft_mag     (fft_mag),
        .fft_valid   (fft_valid),
        .fft_sop     (fft_sop),
        .fft_eop     (fft_eop),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .data_req    (data_req),
        .wr_over     (wr_over),
        .line_cnt    (line_cnt),
        .line_length (line_length),
        .frame_swap  (frame_swap)
    );

    always @(negedge lcd_clk) begin
        if (frame_swap === 1'b1) swaps_seen++;
    end

    function automatic int model_scale(input int mag);
        int s;
        s = mag >> MAG_SHIFT;
        return (s > H_LCD_DISP - 1) ? H_LCD_DISP - 1 : s;
    endfunction

    task automatic tick();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One drawn row: data_req, compare the bar, then wr_over and let the prefetch settle.
    task automatic applyStimulus(input int bin);
        checkOutput($sformatf("line_cnt row%0d", bin), 32'(line_cnt), 32'(bin));
        exp_q.push_back(16'(shown_len[bin]));
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        checkOutput($sformatf("line_length bin%0d", bin), 32'(line_length),
                    32'(exp_q.pop_front()));
        tick();
        tick();
        wr_over = 1'b1;
        tick();
        wr_over = 1'b0;
        if (bin == N_BINS - 1 && staged_full) begin
            for (int i = 0; i < N_BINS; i++) shown_len[i] = staged_len[i];
            staged_full = 1'b0;
            swaps_expected++;
        end
        repeat (4) tick();
    endtask

    task automatic draw_frame();
        for (int b = 0; b < N_BINS; b++) applyStimulus(b);
        checkOutput("frame_swap count", 32'(swaps_seen), 32'(swaps_expected));
        checkOutput("line_cnt after wrap", 32'(line_cnt), 32'd0);
    endtask

    task automatic send_fft(input int n, input bit with_sop);
        for (int i = 0; i < n; i++) begin
            fft_valid = 1'b1;
            fft_mag   = frame_mag[i];
            fft_sop   = with_sop && (i == 0);
            fft_eop   = (i == n - 1);
            tick();
        end
        fft_valid = 1'b0;
        fft_sop   = 1'b0;
        fft_eop   = 1'b0;
        if (with_sop) begin
            for (int i = 0; i < N_BINS && i < n; i++) staged_len[i] = model_scale(int'(frame_mag[i]));
            staged_full = (n >= N_BINS);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < N_BINS; i++) begin
            shown_len[i]  = 0;
            staged_len[i] = 0;
        end

        $display("[TB] reset state");
        repeat (3) tick();
        checkOutput("reset line_cnt", 32'(line_cnt), 32'd0);
        checkOutput("reset line_length", 32'(line_length), 32'd0);
        checkOutput("reset frame_swap", 32'(frame_swap), 32'd0);
        sys_rst_n = 1'b1;
        repeat (4) tick();

        $display("[TB] data before any sop is ignored, blank display frame");
        for (int i = 0; i < 64; i++) frame_mag[i] = 16'h0100;
        send_fft(64, 1'b0);
        draw_frame();

        $display("[TB] frame A mag=i*16, swapped in at wrap");
        for (int i = 0; i < 64; i++) frame_mag[i] = 16'(i * 16);
        send_fft(64, 1'b1);
        draw_frame();

        $display("[TB] frame B with saturation, frame A displayed");
        frame_mag[0] = 16'hFFFF;
        frame_mag[1] = 16'h0010;
        for (int i = 2; i < 64; i++) frame_mag[i] = 16'(i * 200);
        send_fft(64, 1'b1);
        draw_frame();

        $display("[TB] short frame C is discarded, frame B persists");
        for (int i = 0; i < 30; i++) frame_mag[i] = 16'h3000;
        send_fft(30, 1'b1);
        draw_frame();
        draw_frame();

        $display("[TB] 100-bin frame D, extra bins dropped");
        for (int i = 0; i < 100; i++) frame_mag[i] = 16'((i + 5) * 16);
        send_fft(100, 1'b1);
        draw_frame();

        $display("[TB] resync from row 17");
        for (int b = 0; b < 17; b++) applyStimulus(b);
        checkOutput("line_cnt before resync", 32'(line_cnt), 32'd17);
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        tick();
        pixel_xpos = 11'd1;
        pixel_ypos = 11'd1;
        checkOutput("line_cnt after resync", 32'(line_cnt), 32'd0);
        repeat (4) tick();
        applyStimulus(0);
        applyStimulus(1);
        checkOutput("no swap at resync", 32'(swaps_seen), 32'(swaps_expected));

        $display("[TB] reset mid-operation");
        sys_rst_n = 1'b0;
        #2;
        checkOutput("midreset line_cnt", 32'(line_cnt), 32'd0);
        checkOutput("midreset line_length", 32'(line_length), 32'd0);
        checkOutput("midreset frame_swap", 32'(frame_swap), 32'd0);
        for (int i = 0; i < N_BINS; i++) shown_len[i] = 0;
        staged_full = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (4) tick();
        applyStimulus(0);
        applyStimulus(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
